ysyx_22040632_regfile_sb: RTL and testbench
===========================================

# ysyx_22040632_regfile_sb

Parametrised integer register file with a scoreboard for long-latency results, sitting between decode and the execute/divider units of the NPC core. It provides N combinational read ports with same-cycle write bypass, a single-cycle writeback port, and a handshaked long-latency writeback port. A pending bit per register lets decode stall on RAW/WAW hazards against in-flight divide/remainder results instead of serialising the whole core on the divider.

## Interface
Parameters:
- XLEN, 64, register width in bits
- NREG, 32, number of architectural registers; register 0 hardwired to zero
- NRP, 2, number of read ports
- AW, $clog2(NREG), register index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRP×AW  read port indices
- rd_data  out  NRP×XLEN  read data, bypassed
- rd_busy  out  NRP  pending bit of rd_addr[i] (0 for index 0)
- wb_valid  in  1  single-cycle writeback request (always accepted)
- wb_rd  in  AW  writeback index
- wb_data  in  XLEN  writeback data
- lw_valid  in  1  long-latency writeback valid
- lw_rd  in  AW  long writeback index
- lw_data  in  XLEN  long writeback data
- lw_ready  out  1  long writeback accepted this cycle when lw_valid=1
- sb_set_valid  in  1  request to mark a destination pending (long op issue)
- sb_set_rd  in  AW  destination to mark
- sb_set_ready  out  1  set accepted this cycle when sb_set_valid=1
- sb_err  out  1  sticky scoreboard protocol error flag

## Operation
- Storage: NREG×XLEN array plus NREG-bit pending vector. Index 0 always reads 0, never pending; writes/sets to 0 are dropped silently (no error).
- Write arbitration: single write into the array per cycle. wb port has priority. lw_ready = !rst && !wb_valid (independent of lw_valid, lw_rd). lw transfer occurs when lw_valid && lw_ready.
- lw transfer: writes lw_data to lw_rd, clears pending[lw_rd].
- wb write: writes wb_data to wb_rd; pending unchanged.
- Scoreboard set: sb_set_ready = !rst && !pending[sb_set_rd] (uses registered pending only; a same-cycle lw clear of that index does not make it ready). Accepted set marks pending[sb_set_rd] next cycle.
- Same-cycle lw clear and set on different indices: both take effect.
- Read bypass per port i (index ≠ 0): if wb_valid && wb_rd==rd_addr[i] → wb_data; else if lw transfer && lw_rd==rd_addr[i] → lw_data; else array value.
- rd_busy[i] = pending[rd_addr[i]] (registered value; a same-cycle lw transfer to that index still reports busy, but rd_data already bypasses the new value).
- sb_err set (sticky until rst) when: wb_valid to nonzero index with pending set; or lw transfer to nonzero index with pending clear. Write still performed.

## Timing
- Reset: all registers 0, pending all 0, sb_err 0, lw_ready 0, sb_set_ready 0; takes effect at the first posedge with rst=1. rst mid-operation discards all pending state; lw_valid held across reset is not accepted until the first cycle with rst=0.
- Read latency 0 (combinational from rd_addr and write ports). Write visible in array 1 cycle after posedge.
- lw handshake: producer holds lw_valid/lw_rd/lw_data stable until lw_ready; at most one transfer per cycle; back-to-back transfers allowed.
- Set→busy: sb_set accepted at edge k → rd_busy high from cycle k+1 until the edge on which the matching lw transfer occurs.
- No combinational path from lw_valid to lw_ready, nor from sb_set_valid to sb_set_ready.

## Test plan
- Reset/x0: after rst, read x1..x31 → 0, rd_busy 0; wb x0=0xDEAD → x0 reads 0, sb_err 0.
- Bypass: wb x5=0x1234 while port0 reads x5 → rd_data0=0x1234 same cycle; port1 reads x5 next cycle → 0x1234.
- Scoreboard: set x7, next cycle rd_busy for x7 =1; second set x7 → sb_set_ready=0; lw x7=0x55 → busy clears next cycle, rd_data=0x55 in the transfer cycle.
- Arbitration: wb x3=1 and lw x9=2 same cycle → lw_ready=0, x3=1; next cycle (wb idle) lw accepted, x9=2.
- Errors: wb to pending x7 → sb_err=1 and x7 updated; rst clears sb_err; lw to non-pending x4 → sb_err=1.
- Param sweep: XLEN=32, NREG=16, NRP=3 → repeat bypass and scoreboard scenarios on all three ports.

Source files
------------

// File: rtl/ysyx_22040632_regfile_sb.sv
// ysyx_22040632_regfile_sb: register file with bypassed reads and a pending-bit scoreboard for long-latency writebacks
module ysyx_22040632_regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRP = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRP-1:0][AW-1:0]    rd_addr,
  output logic [NRP-1:0][XLEN-1:0]  rd_data,
  output logic [NRP-1:0]            rd_busy,
  input  logic                      wb_valid,
  input  logic [AW-1:0]             wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      lw_valid,
  input  logic [AW-1:0]             lw_rd,
  input  logic [XLEN-1:0]           lw_data,
  output logic                      lw_ready,
  input  logic                      sb_set_valid,
  input  logic [AW-1:0]             sb_set_rd,
  output logic                      sb_set_ready,
  output logic                      sb_err
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic            err_q, err_d, lw_fire, set_fire;
  assign lw_ready     = !rst && !wb_valid;
  assign lw_fire      = lw_valid && lw_ready;
  assign sb_set_ready = !rst && !pend_q[sb_set_rd];
  assign set_fire     = sb_set_valid && sb_set_ready;
  assign sb_err       = err_q;
  always_comb begin
    pend_d = pend_q;
    if (lw_fire) pend_d[lw_rd] = 1'b0;
    if (set_fire) pend_d[sb_set_rd] = 1'b1;
    pend_d[0] = 1'b0;
    err_d = err_q | (wb_valid && wb_rd != '0 && pend_q[wb_rd])
                  | (lw_fire && lw_rd != '0 && !pend_q[lw_rd]);
  end
  // busy reflects registered pending even while a same-cycle lw bypasses its data
  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      rd_data[i] = (rd_addr[i] == '0) ? '0 :
                   (wb_valid && wb_rd == rd_addr[i]) ? wb_data :
                   (lw_fire && lw_rd == rd_addr[i]) ? lw_data : regs_q[rd_addr[i]];
      rd_busy[i] = pend_q[rd_addr[i]];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      err_q  <= 1'b0;
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
      if (wb_valid && wb_rd != '0) regs_q[wb_rd] <= wb_data;
      else if (lw_fire && lw_rd != '0) regs_q[lw_rd] <= lw_data;
    end
  end
endmodule

// File: tb/tb_ysyx_22040632_regfile_sb.sv
// tb_ysyx_22040632_regfile_sb: randomized scoreboard bench for two configurations of the register file
module tb_ysyx_22040632_regfile_sb;
  typedef struct packed {
    logic [2:0][63:0] d;
    logic [2:0]       busy;
    logic             lwr, setr, err;
  } exp_t;
  logic clk = 1'b0, rst_s = 1'b1;
  always #5 clk = ~clk;
  logic [4:0]  s_ra [2][3];
  logic        s_wbv [2], s_lwv [2], s_setv [2];
  logic [4:0]  s_wbrd [2], s_lwrd [2], s_setrd [2];
  logic [63:0] s_wbd [2], s_lwd [2];
  logic [1:0][63:0] a_rd;
  logic [1:0]       a_busy;
  logic             a_lwr, a_setr, a_err;
  logic [2:0][31:0] b_rd;
  logic [2:0]       b_busy;
  logic             b_lwr, b_setr, b_err;
  ysyx_22040632_regfile_sb dut_a (
    .clk(clk), .rst(rst_s),
    .rd_addr({s_ra[0][1], s_ra[0][0]}), .rd_data(a_rd), .rd_busy(a_busy),
    .wb_valid(s_wbv[0]), .wb_rd(s_wbrd[0]), .wb_data(s_wbd[0]),
    .lw_valid(s_lwv[0]), .lw_rd(s_lwrd[0]), .lw_data(s_lwd[0]), .lw_ready(a_lwr),
    .sb_set_valid(s_setv[0]), .sb_set_rd(s_setrd[0]), .sb_set_ready(a_setr), .sb_err(a_err)
  );
  ysyx_22040632_regfile_sb #(.XLEN(32), .NREG(16), .NRP(3)) dut_b (
    .clk(clk), .rst(rst_s),
    .rd_addr({s_ra[1][2][3:0], s_ra[1][1][3:0], s_ra[1][0][3:0]}), .rd_data(b_rd), .rd_busy(b_busy),
    .wb_valid(s_wbv[1]), .wb_rd(s_wbrd[1][3:0]), .wb_data(s_wbd[1][31:0]),
    .lw_valid(s_lwv[1]), .lw_rd(s_lwrd[1][3:0]), .lw_data(s_lwd[1][31:0]), .lw_ready(b_lwr),
    .sb_set_valid(s_setv[1]), .sb_set_rd(s_setrd[1][3:0]), .sb_set_ready(b_setr), .sb_err(b_err)
  );
  int          checks = 0, failures = 0;
  int          nr [2] = '{32, 16};
  int          np [2] = '{2, 3};
  logic [63:0] mk [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
  logic [63:0] mem [2][32];
  bit          pend [2][32];
  bit          merr [2];
  bit          lw_done [2];
  exp_t        q [2][$];
  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
    end
  endtask
  function automatic logic [4:0] pick(input int k);
    return 5'($urandom_range(nr[k] - 1));
  endfunction
  function automatic logic [63:0] rnd(input int k);
    return {$urandom, $urandom} & mk[k];
  endfunction
  // monitor: every cycle the DUT presents its combinational outputs; compare against the oldest expectation
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (q[k].size() != 0) begin
          e = q[k].pop_front();
          a = (k == 0) ? '{d: {64'd0, a_rd[1], a_rd[0]}, busy: {1'b0, a_busy}, lwr: a_lwr, setr: a_setr, err: a_err}
                       : '{d: {{32'd0, b_rd[2]}, {32'd0, b_rd[1]}, {32'd0, b_rd[0]}}, busy: b_busy,
                           lwr: b_lwr, setr: b_setr, err: b_err};
          for (int i = 0; i < np[k]; i++) begin
            chk($sformatf("rd_data%0d", i), k, a.d[i], e.d[i]);
            chk($sformatf("rd_busy%0d", i), k, 64'(a.busy[i]), 64'(e.busy[i]));
          end
          chk("lw_ready", k, 64'(a.lwr), 64'(e.lwr));
          chk("sb_set_ready", k, 64'(a.setr), 64'(e.setr));
          chk("sb_err", k, 64'(a.err), 64'(e.err));
        end
      end
    end
  end
  // driver + reference model: registers as plain arrays, pending as one flag per register
  initial begin
    exp_t e;
    bit   fire;
    int   pl [$];
    for (int k = 0; k < 2; k++) begin
      s_wbv[k] = 0; s_lwv[k] = 0; s_setv[k] = 0; lw_done[k] = 0; merr[k] = 0;
      s_wbrd[k] = 0; s_lwrd[k] = 0; s_setrd[k] = 0; s_wbd[k] = 0; s_lwd[k] = 0;
      for (int i = 0; i < 3; i++) s_ra[k][i] = 0;
      for (int r = 0; r < 32; r++) begin mem[k][r] = 0; pend[k][r] = 0; end
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      rst_s = (cyc < 2) || ($urandom_range(399) == 0);
      for (int k = 0; k < 2; k++) begin
        s_wbv[k]  = ($urandom_range(2) == 0);
        s_wbrd[k] = ($urandom_range(7) == 0) ? 5'd0 : pick(k);
        s_wbd[k]  = rnd(k);
        if (s_wbv[k] && pend[k][s_wbrd[k]] && $urandom_range(31) != 0) s_wbv[k] = 0;
        if (rst_s) s_lwv[k] = 0;
        else if (lw_done[k] || !s_lwv[k]) begin
          s_lwv[k] = 0;
          if ($urandom_range(2) == 0) begin
            pl.delete();
            for (int r = 1; r < nr[k]; r++) if (pend[k][r]) pl.push_back(r);
            if (pl.size() != 0) begin
              s_lwv[k] = 1; s_lwrd[k] = 5'(pl[$urandom_range(pl.size() - 1)]);
            end else if ($urandom_range(15) == 0) begin
              s_lwv[k] = 1; s_lwrd[k] = pick(k);
            end
            s_lwd[k] = rnd(k);
          end
        end
        s_setv[k]  = ($urandom_range(3) == 0);
        s_setrd[k] = pick(k);
        for (int i = 0; i < 3; i++) begin
          case ($urandom_range(3))
            0: s_ra[k][i] = s_wbrd[k];
            1: s_ra[k][i] = s_lwrd[k];
            2: s_ra[k][i] = s_setrd[k];
            default: s_ra[k][i] = pick(k);
          endcase
        end
        e = '0;
        e.lwr  = !rst_s && !s_wbv[k];
        fire   = s_lwv[k] && e.lwr;
        e.setr = !rst_s && !pend[k][s_setrd[k]];
        e.err  = merr[k];
        for (int i = 0; i < 3; i++) begin
          if (s_ra[k][i] == 0) e.d[i] = 0;
          else if (s_wbv[k] && s_wbrd[k] == s_ra[k][i]) e.d[i] = s_wbd[k];
          else if (fire && s_lwrd[k] == s_ra[k][i]) e.d[i] = s_lwd[k];
          else e.d[i] = mem[k][s_ra[k][i]];
          e.busy[i] = pend[k][s_ra[k][i]];
        end
        q[k].push_back(e);
        if (rst_s) begin
          merr[k] = 0;
          for (int r = 0; r < 32; r++) begin mem[k][r] = 0; pend[k][r] = 0; end
        end else begin
          if (s_wbv[k] && s_wbrd[k] != 0 && pend[k][s_wbrd[k]]) merr[k] = 1;
          if (fire && s_lwrd[k] != 0 && !pend[k][s_lwrd[k]]) merr[k] = 1;
          if (s_wbv[k] && s_wbrd[k] != 0) mem[k][s_wbrd[k]] = s_wbd[k];
          else if (fire && s_lwrd[k] != 0) mem[k][s_lwrd[k]] = s_lwd[k];
          if (fire) pend[k][s_lwrd[k]] = 0;
          if (s_setv[k] && e.setr && s_setrd[k] != 0) pend[k][s_setrd[k]] = 1;
        end
        lw_done[k] = fire;
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin s_wbv[k] = 0; s_lwv[k] = 0; s_setv[k] = 0; end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("queue_drained", k, 64'(q[k].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
